// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Bundles the fetch-side inputs, ID-stage outputs and PC-block branch controls
// of branch_ctrl into one interface.
//
// Signals:
//   if_instr/if_pc        fetched instruction and its PC
//   stall                 hold IF/ID and flags, suppress branch outputs
//   flag_wr/flags_in      ALU flag write strobe and {N,Z,C,V}
//   rt_zero               Rt == 0 for CBZ
//   id_instr/id_pc        IF/ID register contents
//   id_valid              id_instr is on the correct path
//   BrTaken/UncondBr      branch decision and target select for the PC block
//   CondAddr19/BrAddr26   raw offset fields of id_instr
//   BrBase                branch adder base (= id_pc)
//   flags_q               architectural {N,Z,C,V}
//   br_taken_cnt/br_seen_cnt  branch statistics (only with BRANCH_CTRL_STATS_EN)
//
// Modports: slave = branch_ctrl, master = the surrounding pipeline/bench.
// -----------------------------------------------------------------------------
interface branch_ctrl_if #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
);
   logic [INSTR_W-1:0] if_instr;
   logic [PC_W-1:0]    if_pc;
   logic               stall;
   logic               flag_wr;
   logic [3:0]         flags_in;
   logic               rt_zero;

   logic [INSTR_W-1:0] id_instr;
   logic [PC_W-1:0]    id_pc;
   logic               id_valid;
   logic               BrTaken;
   logic               UncondBr;
   logic [18:0]        CondAddr19;
   logic [25:0]        BrAddr26;
   logic [PC_W-1:0]    BrBase;
   logic [3:0]         flags_q;
`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0]        br_taken_cnt;
   logic [31:0]        br_seen_cnt;
`endif

   modport slave (
      input  if_instr, if_pc, stall, flag_wr, flags_in, rt_zero,
      output id_instr, id_pc, id_valid, BrTaken, UncondBr,
             CondAddr19, BrAddr26, BrBase, flags_q
`ifdef BRANCH_CTRL_STATS_EN
      , output br_taken_cnt, br_seen_cnt
`endif
   );

   modport master (
      output if_instr, if_pc, stall, flag_wr, flags_in, rt_zero,
      input  id_instr, id_pc, id_valid, BrTaken, UncondBr,
             CondAddr19, BrAddr26, BrBase, flags_q
`ifdef BRANCH_CTRL_STATS_EN
      , input br_taken_cnt, br_seen_cnt
`endif
   );
endinterface

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// IF/ID stage with branch resolution. Latches the fetched instruction and PC,
// decodes B / CBZ / B.cond in ID, owns the NZCV flag register and drives the
// PC block's branch controls. A taken branch squashes the single wrong-path
// instruction fetched behind it (exactly one bubble).
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    branch_ctrl_if.slave (fetch inputs, ID outputs, branch controls)
//
// Optional feature macro: BRANCH_CTRL_STATS_EN
//   Adds saturating br_seen_cnt / br_taken_cnt on the interface.
// -----------------------------------------------------------------------------
module branch_ctrl #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32   // fixed A64 encoding, only 32 supported
) (
   input logic           clk,
   input logic           reset,
   branch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SQUASH = 2'd2
   } state_t;

   state_t             r_state;
   logic [INSTR_W-1:0] r_id_instr;
   logic [PC_W-1:0]    r_id_pc;
   logic               r_id_valid;
   logic [3:0]         r_flags;
`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0]        r_taken_cnt;
   logic [31:0]        r_seen_cnt;
`endif

   logic [3:0]         w_eff_flags;
   logic               w_dec_en;
   logic               w_is_b;
   logic               w_is_cbz;
   logic               w_is_bcond;
   logic               w_br_taken;
   logic               w_uncond;
   logic               w_br_seen;

   // Standard ARM condition evaluation, nzcv = {N,Z,C,V}.
   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic res;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cc[3:1])
         3'b000:  res = z;
         3'b001:  res = c;
         3'b010:  res = n;
         3'b011:  res = v;
         3'b100:  res = c & ~z;
         3'b101:  res = (n == v);
         3'b110:  res = ~z & (n == v);
         default: res = 1'b1;
      endcase
      // Odd codes invert the even one, except 1111 which is also "always".
      if (cc[0] && (cc[3:1] != 3'b111))
         res = ~res;
      return res;
   endfunction

   always_comb begin
      w_eff_flags = '0;
      w_dec_en    = 1'b0;
      w_is_b      = 1'b0;
      w_is_cbz    = 1'b0;
      w_is_bcond  = 1'b0;
      w_br_taken  = 1'b0;
      w_uncond    = 1'b0;
      w_br_seen   = 1'b0;

      // Same-cycle forward so an ADDS/SUBS immediately ahead of B.cond is seen.
      w_eff_flags = bus.flag_wr ? bus.flags_in : r_flags;

      // SQUASH needs no explicit term: r_id_valid is already 0 there.
      w_dec_en = reset & r_id_valid & ~bus.stall & (r_state != ST_FILL);

      w_is_b     = (r_id_instr[31:26] == 6'b000101);
      w_is_cbz   = (r_id_instr[31:24] == 8'b10110100);
      w_is_bcond = (r_id_instr[31:24] == 8'b01010100);

      if (w_dec_en) begin
         if (w_is_b) begin
            w_br_taken = 1'b1;
            w_uncond   = 1'b1;
            w_br_seen  = 1'b1;
         end else if (w_is_cbz) begin
            w_br_taken = bus.rt_zero;
            w_br_seen  = 1'b1;
         end else if (w_is_bcond) begin
            w_br_taken = cond_pass(r_id_instr[3:0], w_eff_flags);
            w_br_seen  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_FILL;
         r_id_instr <= '0;
         r_id_pc    <= '0;
         r_id_valid <= 1'b0;
         r_flags    <= '0;
`ifdef BRANCH_CTRL_STATS_EN
         r_taken_cnt <= '0;
         r_seen_cnt  <= '0;
`endif
      end else if (!bus.stall) begin
         r_id_instr <= bus.if_instr;
         r_id_pc    <= bus.if_pc;
         if (bus.flag_wr)
            r_flags <= bus.flags_in;

         case (r_state)
            ST_FILL: begin
               r_id_valid <= 1'b1;
               r_state    <= ST_RUN;
            end
            ST_RUN: begin
               if (w_br_taken) begin
                  r_id_valid <= 1'b0;
                  r_state    <= ST_SQUASH;
               end else begin
                  r_id_valid <= 1'b1;
               end
            end
            ST_SQUASH: begin
               r_id_valid <= 1'b1;
               r_state    <= ST_RUN;
            end
            default: begin
               r_id_valid <= 1'b0;
               r_state    <= ST_FILL;
            end
         endcase

`ifdef BRANCH_CTRL_STATS_EN
         if (w_br_seen && (r_seen_cnt != '1))
            r_seen_cnt <= r_seen_cnt + 32'd1;
         if (w_br_taken && (r_taken_cnt != '1))
            r_taken_cnt <= r_taken_cnt + 32'd1;
`endif
      end
   end

   assign bus.id_instr   = r_id_instr;
   assign bus.id_pc      = r_id_pc;
   assign bus.id_valid   = r_id_valid;
   assign bus.BrTaken    = w_br_taken;
   assign bus.UncondBr   = w_uncond;
   assign bus.CondAddr19 = r_id_instr[23:5];
   assign bus.BrAddr26   = r_id_instr[25:0];
   assign bus.BrBase     = r_id_pc;
   assign bus.flags_q    = r_flags;
`ifdef BRANCH_CTRL_STATS_EN
   assign bus.br_taken_cnt = r_taken_cnt;
   assign bus.br_seen_cnt  = r_seen_cnt;
`else
   // Statistics disabled: the seen strobe has no consumer.
   logic w_unused;
   assign w_unused = w_br_seen;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Directed, table-driven bench for branch_ctrl. Each table row holds the inputs
// driven for one cycle and the outputs expected just before that cycle's edge.
// A hand-written loop then sweeps all 16 condition codes.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

   localparam logic [31:0] I_B    = 32'h14000004;
   localparam logic [31:0] I_NOP  = 32'hD503201F;
   localparam logic [31:0] I_ADD  = 32'h8B000000;
   localparam logic [31:0] I_CBZ  = 32'hB4000060;
   localparam logic [31:0] I_BEQ  = 32'h54000040;

   typedef struct {
      logic        chk;
      logic        rst;
      logic        stall;
      logic        fwr;
      logic [3:0]  fin;
      logic        rtz;
      logic [31:0] ifi;
      logic [63:0] ifp;
      logic        ev;
      logic [31:0] ei;
      logic [63:0] ep;
      logic        ebr;
      logic        eun;
      logic [3:0]  ef;
   } vec_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   vec_t tv [18];

   branch_ctrl_if #(.PC_W(64), .INSTR_W(32)) bus ();

   branch_ctrl #(.PC_W(64), .INSTR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx,
                        input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      //         chk  rst  stl  fwr  fin      rtz  if_instr if_pc      ev   e_instr e_pc       ebr  eun  eflags
      tv[0]  = '{1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,I_B,   64'h000, 1'b0,32'h0, 64'h000, 1'b0,1'b0,4'b0000};
      tv[1]  = '{1'b1,1'b0,1'b0,1'b1,4'b1111,1'b0,I_B,   64'h000, 1'b0,32'h0, 64'h000, 1'b0,1'b0,4'b0000};
      tv[2]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_B,   64'h100, 1'b0,32'h0, 64'h000, 1'b0,1'b0,4'b0000};
      tv[3]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_ADD, 64'h104, 1'b1,I_B,   64'h100, 1'b1,1'b1,4'b0000};
      tv[4]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_CBZ, 64'h110, 1'b0,I_ADD, 64'h104, 1'b0,1'b0,4'b0000};
      tv[5]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_CBZ, 64'h114, 1'b1,I_CBZ, 64'h110, 1'b0,1'b0,4'b0000};
      tv[6]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b1,I_NOP, 64'h118, 1'b1,I_CBZ, 64'h114, 1'b1,1'b0,4'b0000};
      tv[7]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_BEQ, 64'h120, 1'b0,I_NOP, 64'h118, 1'b0,1'b0,4'b0000};
      tv[8]  = '{1'b1,1'b1,1'b0,1'b1,4'b0100,1'b0,I_NOP, 64'h124, 1'b1,I_BEQ, 64'h120, 1'b1,1'b0,4'b0000};
      tv[9]  = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_B,   64'h128, 1'b0,I_NOP, 64'h124, 1'b0,1'b0,4'b0100};
      tv[10] = '{1'b1,1'b1,1'b1,1'b1,4'b1111,1'b0,I_NOP, 64'h12C, 1'b1,I_B,   64'h128, 1'b0,1'b0,4'b0100};
      tv[11] = '{1'b1,1'b1,1'b1,1'b1,4'b1111,1'b0,I_NOP, 64'h12C, 1'b1,I_B,   64'h128, 1'b0,1'b0,4'b0100};
      tv[12] = '{1'b1,1'b1,1'b1,1'b1,4'b1111,1'b0,I_NOP, 64'h12C, 1'b1,I_B,   64'h128, 1'b0,1'b0,4'b0100};
      tv[13] = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_NOP, 64'h12C, 1'b1,I_B,   64'h128, 1'b1,1'b1,4'b0100};
      tv[14] = '{1'b1,1'b0,1'b0,1'b0,4'b0000,1'b0,I_B,   64'h300, 1'b0,I_NOP, 64'h12C, 1'b0,1'b0,4'b0100};
      tv[15] = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_B,   64'h300, 1'b0,32'h0, 64'h000, 1'b0,1'b0,4'b0000};
      tv[16] = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_NOP, 64'h304, 1'b1,I_B,   64'h300, 1'b1,1'b1,4'b0000};
      tv[17] = '{1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,I_NOP, 64'h310, 1'b0,I_NOP, 64'h304, 1'b0,1'b0,4'b0000};

      for (int i = 0; i < 18; i++) begin
         reset        = tv[i].rst;
         bus.stall    = tv[i].stall;
         bus.flag_wr  = tv[i].fwr;
         bus.flags_in = tv[i].fin;
         bus.rt_zero  = tv[i].rtz;
         bus.if_instr = tv[i].ifi;
         bus.if_pc    = tv[i].ifp;
         #1;
         if (tv[i].chk) begin
            vectors++;
            check("id_valid",   i, 64'(bus.id_valid),   64'(tv[i].ev));
            check("id_instr",   i, 64'(bus.id_instr),   64'(tv[i].ei));
            check("id_pc",      i, bus.id_pc,           tv[i].ep);
            check("BrTaken",    i, 64'(bus.BrTaken),    64'(tv[i].ebr));
            check("UncondBr",   i, 64'(bus.UncondBr),   64'(tv[i].eun));
            check("flags_q",    i, 64'(bus.flags_q),    64'(tv[i].ef));
            check("CondAddr19", i, 64'(bus.CondAddr19), 64'(tv[i].ei[23:5]));
            check("BrAddr26",   i, 64'(bus.BrAddr26),   64'(tv[i].ei[25:0]));
            check("BrBase",     i, bus.BrBase,          tv[i].ep);
         end
         next_cycle();
      end

      // Condition sweep against NZCV=1001 held in flags_q (no forwarding).
      // Each code gets two cycles: fetch B.cond, then evaluate it in ID while a
      // NOP is fetched. The ID slot before each B.cond is always a NOP, so the
      // B.cond always arrives valid.
      begin
         logic [15:0] exp_taken;
         // bit c: EQ0 NE1 HS0 LO1 MI1 PL0 VS1 VC0 HI0 LS1 GE1 LT0 GT1 LE0 AL1 AL1
         exp_taken = 16'b1101_0110_0101_1010;
         reset        = 1'b1;
         bus.stall    = 1'b0;
         bus.rt_zero  = 1'b0;
         bus.flag_wr  = 1'b1;
         bus.flags_in = 4'b1001;
         bus.if_instr = I_NOP;
         bus.if_pc    = 64'h400;
         next_cycle();
         bus.flag_wr  = 1'b0;
         bus.flags_in = 4'b0110;   // ignored while flag_wr=0
         for (int c = 0; c < 16; c++) begin
            bus.if_instr = 32'h54000020 | 32'(c);
            bus.if_pc    = 64'h500 + 64'(8 * c);
            next_cycle();
            bus.if_instr = I_NOP;
            bus.if_pc    = 64'h504 + 64'(8 * c);
            #1;
            vectors++;
            check("cond_valid",   c, 64'(bus.id_valid), 64'd1);
            check("cond_taken",   c, 64'(bus.BrTaken),  64'(exp_taken[c]));
            check("cond_uncond",  c, 64'(bus.UncondBr), 64'd0);
            check("cond_flags_q", c, 64'(bus.flags_q),  64'h9);
            next_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
